// File: rtl/load_store_unit.sv
// Load/store unit: issues one RV32I load/store at a time to the 64-bit data memory and returns a 32-bit response.
// Define LSU_MISALIGN_SPLIT_EN to run misaligned in-range accesses as sequential byte accesses.
module load_store_unit #(
    parameter int MEM_BYTES  = 32768,
    parameter int MEM_WIDTH  = 15,
    parameter int MLEN       = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_error,
    output logic [2:0]           mem_funct3,
    output logic [MEM_WIDTH-1:0] mem_rd_addr,
    input  logic [MLEN-1:0]      mem_rd_data,
    output logic [MEM_WIDTH-1:0] mem_wr_addr,
    output logic [MLEN-1:0]      mem_wr_data,
    output logic                 mem_wr_en,
    input  logic                 mem_error
);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  ISSUE = 2'd1;
    localparam logic [1:0]  WAIT  = 2'd2;
    localparam logic [1:0]  RESP  = 2'd3;
    localparam logic [2:0]  RD_LAT    = 3'(RD_LATENCY);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] raw_q, raw_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        err_acc_q, err_acc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [1:0]           last_idx;
    logic [32:0]          end_addr;
    logic                 illegal, misaligned, out_of_range, split, req_err, last_beat, active;
    logic [MEM_WIDTH-1:0] mem_addr;
    logic [7:0]           wr_byte;
    logic [MLEN-1:0]      wr_repl;
    logic [31:0]          raw_cap;
    logic                 unused_rd_hi;

    assign unused_rd_hi = ^mem_rd_data[MLEN-1:32];

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'b0, d[7:0]};
            3'b101:  extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // Legality is judged on the latched request; the wide end address also catches 32-bit wrap.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
        end_addr     = {1'b0, addr_q} + {31'b0, last_idx};
        illegal      = (funct3_q[1:0] == 2'b11) || (we_q && funct3_q[2]) ||
                       (funct3_q[2] && funct3_q[1:0] == 2'b10);
        misaligned   = (funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                       (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
        out_of_range = end_addr >= MEM_LIMIT;
        split        = SPLIT_EN && misaligned;
        req_err      = illegal || out_of_range || (misaligned && !SPLIT_EN);
        last_beat    = !split || (idx_q == last_idx);
        active       = (state_q == ISSUE || state_q == WAIT) && !req_err;
    end

    always_comb begin
        mem_addr = addr_q[MEM_WIDTH-1:0] + MEM_WIDTH'(split ? idx_q : 2'd0);
        wr_byte  = 8'(wdata_q >> {idx_q, 3'b000});
        if (split) begin
            wr_repl = {(MLEN/8){wr_byte}};
        end else begin
            case (funct3_q[1:0])
                2'b00:   wr_repl = {(MLEN/8){wdata_q[7:0]}};
                2'b01:   wr_repl = {(MLEN/16){wdata_q[15:0]}};
                default: wr_repl = {(MLEN/32){wdata_q}};
            endcase
        end
        if (split) begin
            raw_cap = (raw_q & ~(32'hFF << {idx_q, 3'b000})) |
                      ({24'b0, mem_rd_data[7:0]} << {idx_q, 3'b000});
        end else begin
            raw_cap = mem_rd_data[31:0];
        end
    end

    // Split beats always use byte opcodes; whole loads ask for raw unsigned bytes.
    assign mem_wr_en   = (state_q == ISSUE) && !req_err && we_q;
    assign mem_funct3  = !active ? 3'b000 :
                         split   ? {!we_q, 2'b00} :
                         we_q    ? funct3_q : {1'b1, funct3_q[1:0]};
    assign mem_rd_addr = (active && !we_q) ? mem_addr : '0;
    assign mem_wr_addr = mem_wr_en ? mem_addr : '0;
    assign mem_wr_data = mem_wr_en ? wr_repl : '0;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        raw_d        = raw_q;
        lat_cnt_d    = lat_cnt_q;
        idx_d        = idx_q;
        err_acc_d    = err_acc_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    raw_d     = '0;
                    lat_cnt_d = '0;
                    idx_d     = '0;
                    err_acc_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (req_err) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_error_d = 1'b1;
                end else if (we_q) begin
                    err_acc_d = err_acc_q | mem_error;
                    if (last_beat) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_error_d = err_acc_q | mem_error;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = 3'd1;
                end
            end
            WAIT: begin
                if (lat_cnt_q == RD_LAT) begin
                    raw_d     = raw_cap;
                    err_acc_d = err_acc_q | mem_error;
                    if (last_beat) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = extend(funct3_q, raw_cap);
                        resp_error_d = err_acc_q | mem_error;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            default: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            raw_q        <= '0;
            lat_cnt_q    <= '0;
            idx_q        <= '0;
            err_acc_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            raw_q        <= raw_d;
            lat_cnt_q    <= lat_cnt_d;
            idx_q        <= idx_d;
            err_acc_q    <= err_acc_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, directed vector table, hand-written corner
// sequences and randomized requests checked against a byte-level reference model.
module tb_load_store_unit;
    localparam int MEM_BYTES  = 32768;
    localparam int MEM_WIDTH  = 15;
    localparam int MLEN       = 64;
    localparam int RD_LATENCY = 1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_error, mem_wr_en, mem_error;
    logic [2:0]           req_funct3, mem_funct3;
    logic [31:0]          req_addr, req_wdata, resp_rdata;
    logic [MEM_WIDTH-1:0] mem_rd_addr, mem_wr_addr;
    logic [MLEN-1:0]      mem_rd_data, mem_wr_data;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .MEM_WIDTH(MEM_WIDTH), .MLEN(MLEN), .RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_funct3(mem_funct3), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_error(mem_error));

    always #5 clk = ~clk;

    // Data memory: byte array, writes at the edge, reads sampled at the edge and delivered RD_LATENCY later.
    logic [7:0]  dmem   [MEM_BYTES];
    logic [7:0]  shadow [MEM_BYTES];
    logic [63:0] rd_pipe[RD_LATENCY];
    int wr_cnt = 0;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [63:0] rd8(input logic [MEM_WIDTH-1:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = dmem[(int'(a) + i) % MEM_BYTES];
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            for (int i = 0; i < nbytes(mem_funct3[1:0]); i++)
                dmem[(int'(mem_wr_addr) + i) % MEM_BYTES] <= mem_wr_data[8*i +: 8];
        end
        rd_pipe[0] <= rd8(mem_rd_addr);
        for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rd_data = rd_pipe[RD_LATENCY-1];

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: legality, per-byte memory image and extension computed from the access rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er,
                                  output int lat, output int nwr);
        int size, beats;
        bit bad, misal;
        longint v;
        size  = nbytes(f3[1:0]);
        bad   = (f3[1:0] == 2'b11) || (we && f3[2]) || (f3 == 3'b110);
        misal = (a % size) != 0;
        if (longint'(a) + size - 1 >= MEM_BYTES) bad = 1;
        if (misal && !SPLIT) bad = 1;
        rd = 0; er = 0; nwr = 0; lat = 1;
        if (bad) begin
            er = 1;
            return;
        end
        beats = misal ? size : 1;
        if (we) begin
            for (int i = 0; i < size; i++) shadow[a + i] = wd[8*i +: 8];
            lat = beats;
            nwr = beats;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(shadow[a + i]) << (8*i));
            if (!f3[2] && size < 4 && v >= (64'sd1 << (8*size - 1))) v = v - (64'sd1 << (8*size));
            rd  = v[31:0];
            lat = beats * (1 + RD_LATENCY);
        end
    endfunction

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd, output logic er, output int lat, output int nwr);
        int n, w0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        w0  = wr_cnt;
        lat = 0;
        while (!resp_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) chk("resp_timeout", resp_valid, 1);
        rd = resp_rdata;
        er = resp_error;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        nwr = wr_cnt - w0;
        chk("post_hs_valid", resp_valid, 0);
        chk("post_hs_ready", req_ready, 1);
    endtask

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] rd; logic er; int lat; int nwr;
    } vec_t;

    initial begin
        vec_t vt[$];
        logic [31:0] rd, m_rd, a;
        logic er, m_er, we;
        logic [2:0] f3;
        int lat, nwr, m_lat, m_nwr;

        for (int i = 0; i < MEM_BYTES; i++) begin dmem[i] = 8'h00; shadow[i] = 8'h00; end
        for (int k = 0; k < RD_LATENCY; k++) rd_pipe[k] = '0;
        rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0; mem_error = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_mem_outs", {mem_wr_en, mem_funct3, mem_rd_addr, mem_wr_addr}, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        rst = 1'b0;

        vt.push_back('{1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0, 1, 1});
        vt.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0});
        vt.push_back('{1'b0, 3'b000, 32'h103,  32'h0,        32'hFFFFFFDE, 1'b0, 2, 0});
        vt.push_back('{1'b0, 3'b100, 32'h103,  32'h0,        32'h000000DE, 1'b0, 2, 0});
        vt.push_back('{1'b0, 3'b001, 32'h102,  32'h0,        32'hFFFFDEAD, 1'b0, 2, 0});
        vt.push_back('{1'b0, 3'b101, 32'h100,  32'h0,        32'h0000BEEF, 1'b0, 2, 0});
        vt.push_back('{1'b1, 3'b010, 32'h104,  32'h11223344, 32'h0,        1'b0, 1, 1});
        vt.push_back('{1'b0, 3'b010, 32'h102,  32'h0, SPLIT ? 32'h3344DEAD : 32'h0, !SPLIT, SPLIT ? 8 : 1, 0});
        vt.push_back('{1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{1'b1, 3'b100, 32'h100,  32'h12345678, 32'h0,        1'b1, 1, 0});
        vt.push_back('{1'b0, 3'b010, 32'h8000, 32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{1'b0, 3'b110, 32'h100,  32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{1'b1, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{1'b1, 3'b001, 32'h201,  32'h0000ABCD, 32'h0,        !SPLIT, SPLIT ? 2 : 1, SPLIT ? 2 : 0});
        vt.push_back('{1'b0, 3'b101, 32'h201,  32'h0, SPLIT ? 32'h0000ABCD : 32'h0, !SPLIT, SPLIT ? 4 : 1, 0});
        vt.push_back('{1'b0, 3'b010, 32'h7FFE, 32'h0,        32'h0,        1'b1, 1, 0});
        vt.push_back('{1'b1, 3'b000, 32'h7FFF, 32'h0000005A, 32'h0,        1'b0, 1, 1});
        vt.push_back('{1'b0, 3'b000, 32'h7FFF, 32'h0,        32'h0000005A, 1'b0, 2, 0});

        foreach (vt[i]) begin
            model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, m_rd, m_er, m_lat, m_nwr);
            run_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, 0, rd, er, lat, nwr);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("vec%0d_error", i), er, vt[i].er);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("vec%0d_writes", i), nwr, vt[i].nwr);
        end

        // Backpressure: response held for 3 cycles while a new request is offered.
        model(1'b0, 3'b010, 32'h100, 0, m_rd, m_er, m_lat, m_nwr);
        run_req(1'b0, 3'b010, 32'h100, 0, 3, rd, er, lat, nwr);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        chk("bp_latency", lat, 2);

        // Memory error reported on a store and on a load.
        mem_error = 1'b1;
        model(1'b1, 3'b010, 32'h300, 32'h12345678, m_rd, m_er, m_lat, m_nwr);
        run_req(1'b1, 3'b010, 32'h300, 32'h12345678, 0, rd, er, lat, nwr);
        chk("memerr_store", er, 1);
        run_req(1'b0, 3'b010, 32'h300, 0, 0, rd, er, lat, nwr);
        chk("memerr_load", er, 1);
        mem_error = 1'b0;
        run_req(1'b0, 3'b010, 32'h300, 0, 0, rd, er, lat, nwr);
        chk("memerr_after_rdata", rd, 32'h12345678);
        chk("memerr_after_error", er, 0);

        // Reset while a load waits on memory.
        req_we = 0; req_funct3 = 3'b010; req_addr = 32'h104; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("wait_rd_addr", mem_rd_addr, 15'h104);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_wr_en", mem_wr_en, 0);
        @(posedge clk); #1;
        chk("midrst_no_resp", resp_valid, 0);
        model(1'b0, 3'b010, 32'h104, 0, m_rd, m_er, m_lat, m_nwr);
        run_req(1'b0, 3'b010, 32'h104, 0, 0, rd, er, lat, nwr);
        chk("midrst_next_rdata", rd, 32'h11223344);
        chk("midrst_next_latency", lat, 2);

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 32'h8000 + $urandom_range(0, 255);
                1:       a = $urandom;
                2, 3:    a = 32'h7FF8 + $urandom_range(0, 7);
                default: a = 32'h100 + $urandom_range(0, 63);
            endcase
            m_rd = $urandom;
            model(we, f3, a, m_rd, rd, er, m_lat, m_nwr);
            run_req(we, f3, a, m_rd, $urandom_range(0, 2), m_rd, m_er, lat, nwr);
            chk($sformatf("rnd%0d_rdata", t), m_rd, rd);
            chk($sformatf("rnd%0d_error", t), m_er, er);
            chk($sformatf("rnd%0d_latency", t), lat, m_lat);
            chk($sformatf("rnd%0d_writes", t), nwr, m_nwr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
